disparity_stream_tx: RTL and testbench

- Output-side transmitter for the stereo matching core.
- Accepts the core's disparity stream: one disparity per cycle, qualified by a data-valid strobe, no backpressure.
- Packs disparities into byte lanes of OW-bit words, buffers the words in a FIFO, and transmits them over a valid/ready stream with per-row last and keep markings.
- Sits between the stereo_match output and the host/DMA interface.

---
 rtl/stereo_tx_pkg.sv | 41 ++++
 rtl/sync_fifo_sv.sv | 87 ++++++++
 rtl/disparity_stream_tx.sv | 154 +++++++++++++++
 tb/tb_disparity_stream_tx.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stereo_tx_pkg.sv
// Shared definitions for the disparity stream transmitter.
// Lane count, disparity width and the layout of one FIFO entry
// ({user, last, keep, data}, low to high: data, keep, last, user).
// The user bit exists only when DISP_TX_SOF_EN is defined.
package stereo_tx_pkg;

  // Byte lanes in an output word of width ow.
  function automatic int lane_count(input int ow);
    return ow / 8;
  endfunction

  // Bits needed to carry one disparity in the range 0..d-1.
  function automatic int disp_bits(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

  localparam int LAST_W = 1;
`ifdef DISP_TX_SOF_EN
  localparam int USER_W = 1;
`else
  localparam int USER_W = 0;
`endif

  // Field positions inside a FIFO entry.
  function automatic int keep_lsb(input int ow);
    return ow;
  endfunction

  function automatic int last_pos(input int ow);
    return ow + lane_count(ow);
  endfunction

  function automatic int user_pos(input int ow);
    return last_pos(ow) + LAST_W;
  endfunction

  function automatic int entry_width(input int ow);
    return ow + lane_count(ow) + LAST_W + USER_W;
  endfunction

endpackage

// File: rtl/sync_fifo_sv.sv
// Synchronous FIFO with a registered show-ahead head.
// The head register always holds the oldest entry, so a word written
// into an empty FIFO is presented on the very next cycle. Capacity is
// DEPTH entries including the head. A write while full is accepted only
// if the head is popped in the same cycle; otherwise the caller must
// treat it as dropped.
module sync_fifo_sv #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_ready_i,
  output logic [W-1:0] rd_data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] rd_next_ptr;
  logic [AW:0]   count_q;
  logic [W-1:0]  head_q;
  logic          head_valid_q;
  logic          pop;
  logic          push;

  assign full_o      = (count_q == (AW+1)'(DEPTH));
  assign empty_o     = !head_valid_q;
  assign rd_data_o   = head_q;
  assign pop         = head_valid_q && rd_ready_i;
  assign push        = wr_en_i && (!full_o || pop);
  assign rd_next_ptr = rd_ptr_q + 1'b1;

  // Storage array write port; no reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointers, occupancy and the registered head word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_next_ptr;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (!head_valid_q) begin
        // Empty: the incoming word goes straight to the head.
        if (push) begin
          head_q       <= wr_data_i;
          head_valid_q <= 1'b1;
        end
      end else if (pop) begin
        if (count_q >= (AW+1)'(2)) begin
          // The following entry is already in the array.
          head_q <= mem_q[rd_next_ptr];
        end else if (push) begin
          // Last entry leaves while a new one arrives: bypass.
          head_q <= wr_data_i;
        end else begin
          head_valid_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/disparity_stream_tx.sv
// Disparity stream transmitter: packs one disparity per valid cycle into
// byte lanes of OW-bit words, queues the words and sends them over a
// valid/ready stream with per-row tlast and tkeep.
// Optional feature macro: DISP_TX_SOF_EN adds o_tuser (start of frame,
// set on the first word of row 0) and a row counter 0..ROWS-1.
module disparity_stream_tx
  import stereo_tx_pkg::*;
#(
  parameter int D          = 64,
  parameter int M          = 450,
  parameter int OW         = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int ROWS       = 375
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_dval,
  input  logic [disp_bits(D)-1:0] i_data,
  output logic [OW-1:0]           o_tdata,
  output logic [OW/8-1:0]         o_tkeep,
  output logic                    o_tlast,
  output logic                    o_tvalid,
  input  logic                    i_tready,
  output logic                    o_overflow
`ifdef DISP_TX_SOF_EN
  ,
  output logic                    o_tuser
`endif
);

  localparam int L  = lane_count(OW);
  localparam int LW = (L > 1) ? $clog2(L) : 1;
  localparam int CW = (M > 1) ? $clog2(M) : 1;
  localparam int EW = entry_width(OW);

  // Packer state.
  logic [LW-1:0] lane_q;
  logic [CW-1:0] col_q;
  logic [OW-1:0] word_q;
  logic [OW-1:0] word_d;
  logic [L-1:0]  keep_d;
  logic          word_done;
  logic          row_end;

  // Completed word waiting one cycle before entering the FIFO.
  logic          push_q;
  logic [OW-1:0] push_data_q;
  logic [L-1:0]  push_keep_q;
  logic          push_last_q;

  logic          overflow_q;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic [EW-1:0] fifo_wr_data;
  logic [EW-1:0] fifo_rd_data;

  assign row_end   = (col_q == CW'(M - 1));
  assign word_done = (lane_q == LW'(L - 1)) || row_end;

  // Insert the zero-extended sample into its lane; lanes up to the current
  // one are marked valid.
  for (genvar gi = 0; gi < L; gi++) begin : g_lane
    assign word_d[8*gi +: 8] = (int'(lane_q) == gi) ? 8'(i_data) : word_q[8*gi +: 8];
    assign keep_d[gi]        = (int'(lane_q) >= gi);
  end

  // Packer: lane/column tracking and registration of completed words.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      lane_q      <= '0;
      col_q       <= '0;
      word_q      <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      push_keep_q <= '0;
      push_last_q <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (i_dval) begin
        if (word_done) begin
          push_q      <= 1'b1;
          push_data_q <= word_d;
          push_keep_q <= keep_d;
          push_last_q <= row_end;
          word_q      <= '0;
          lane_q      <= '0;
        end else begin
          word_q <= word_d;
          lane_q <= lane_q + 1'b1;
        end
        col_q <= row_end ? '0 : col_q + 1'b1;
      end
    end
  end

  assign fifo_pop = !fifo_empty && i_tready;

  // Sticky overflow: a registered word found the FIFO full with no pop.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      overflow_q <= 1'b0;
    end else if (push_q && fifo_full && !fifo_pop) begin
      overflow_q <= 1'b1;
    end
  end

`ifdef DISP_TX_SOF_EN
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [RW-1:0] row_q;
  logic          push_user_q;

  // Row counter advances on every tlast word; start of frame is the first
  // word of row 0 (the only word that can end before column L).
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      row_q       <= '0;
      push_user_q <= 1'b0;
    end else if (i_dval && word_done) begin
      push_user_q <= (row_q == '0) && (col_q < CW'(L));
      if (row_end) begin
        row_q <= (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
      end
    end
  end

  assign fifo_wr_data = {push_user_q, push_last_q, push_keep_q, push_data_q};
  assign o_tuser      = fifo_rd_data[user_pos(OW)];
`else
  assign fifo_wr_data = {push_last_q, push_keep_q, push_data_q};
`endif

  sync_fifo_sv #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (i_clk),
    .rst_ni     (i_rstn),
    .wr_en_i    (push_q),
    .wr_data_i  (fifo_wr_data),
    .rd_ready_i (i_tready),
    .rd_data_o  (fifo_rd_data),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign o_tdata    = fifo_rd_data[OW-1:0];
  assign o_tkeep    = fifo_rd_data[keep_lsb(OW) +: L];
  assign o_tlast    = fifo_rd_data[last_pos(OW)];
  assign o_tvalid   = !fifo_empty;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_disparity_stream_tx.sv
// Bench for disparity_stream_tx: a transaction-level model (row buffer,
// word queue of bounded depth, sticky overflow) is checked against the DUT
// on every negative clock edge, and directed phases pin the model with
// hand-computed words.
module tb_disparity_stream_tx;

  localparam int M     = 450;
  localparam int L     = 4;
  localparam int DEPTH = 16;
`ifdef DISP_TX_SOF_EN
  localparam int ROWS  = 2;
`else
  localparam int ROWS  = 375;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        dval = 1'b0;
  logic [5:0]  data = '0;
  logic        tready = 1'b0;
  logic [31:0] o_tdata;
  logic [3:0]  o_tkeep;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_overflow;
`ifdef DISP_TX_SOF_EN
  logic        o_tuser;
`endif

  disparity_stream_tx #(
    .D          (64),
    .M          (M),
    .OW         (32),
    .FIFO_DEPTH (DEPTH),
    .ROWS       (ROWS)
  ) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_dval     (dval),
    .i_data     (data),
    .o_tdata    (o_tdata),
    .o_tkeep    (o_tkeep),
    .o_tlast    (o_tlast),
    .o_tvalid   (o_tvalid),
    .i_tready   (tready),
    .o_overflow (o_overflow)
`ifdef DISP_TX_SOF_EN
    ,
    .o_tuser    (o_tuser)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
  } word_t;

  word_t        exp_q[$];
  word_t        pend;
  bit           pend_v = 0;
  bit           exp_ovf = 0;
  int           m_col = 0;
  int           m_row = 0;
  int           m_start = 0;
  int unsigned  m_lanes[$];

  // Observed transfers for the directed checks.
  logic [31:0]  obs_data[$];
  logic [3:0]   obs_keep[$];
  logic         obs_last[$];
  logic         obs_user[$];

  task automatic clear_obs();
    obs_data.delete();
    obs_keep.delete();
    obs_last.delete();
    obs_user.delete();
  endtask

  // Compare DUT to model, then advance the model across the coming edge.
  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_tvalid", 64'(o_tvalid), 64'd0);
      chk("rst_tdata", 64'(o_tdata), 64'd0);
      chk("rst_tkeep", 64'(o_tkeep), 64'd0);
      chk("rst_tlast", 64'(o_tlast), 64'd0);
      chk("rst_overflow", 64'(o_overflow), 64'd0);
      exp_q.delete();
      m_lanes.delete();
      pend_v  = 0;
      exp_ovf = 0;
      m_col   = 0;
      m_row   = 0;
    end else begin
      bit pop;
      bit full;
      chk("tvalid", 64'(o_tvalid), 64'(exp_q.size() != 0));
      chk("overflow", 64'(o_overflow), 64'(exp_ovf));
      if (exp_q.size() != 0) begin
        chk("tdata", 64'(o_tdata), 64'(exp_q[0].data));
        chk("tkeep", 64'(o_tkeep), 64'(exp_q[0].keep));
        chk("tlast", 64'(o_tlast), 64'(exp_q[0].last));
`ifdef DISP_TX_SOF_EN
        chk("tuser", 64'(o_tuser), 64'(exp_q[0].user));
`endif
      end
      if (o_tvalid && tready) begin
        obs_data.push_back(o_tdata);
        obs_keep.push_back(o_tkeep);
        obs_last.push_back(o_tlast);
`ifdef DISP_TX_SOF_EN
        obs_user.push_back(o_tuser);
`else
        obs_user.push_back(1'b0);
`endif
      end
      pop  = (exp_q.size() != 0) && tready;
      full = (exp_q.size() == DEPTH);
      if (pop) void'(exp_q.pop_front());
      if (pend_v) begin
        if (!full || pop) exp_q.push_back(pend);
        else exp_ovf = 1;
      end
      pend_v = 0;
      if (dval) begin
        bit done;
        if (m_lanes.size() == 0) m_start = m_col;
        m_lanes.push_back(int'(data));
        done = (m_col == M - 1);
        if (m_lanes.size() == L || done) begin
          word_t w;
          w.data = '0;
          for (int k = 0; k < m_lanes.size(); k++)
            w.data = w.data | (32'(m_lanes[k]) << (8 * k));
          w.keep = 4'((1 << m_lanes.size()) - 1);
          w.last = done;
          w.user = (m_start == 0) && (m_row == 0);
          pend   = w;
          pend_v = 1;
          m_lanes.delete();
          if (done) m_row = (m_row + 1) % ROWS;
        end
        m_col = done ? 0 : m_col + 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle(input logic v, input logic [5:0] d, input logic rdy);
    @(posedge clk);
    #1;
    dval   = v;
    data   = d;
    tready = rdy;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rstn = 1'b0;
    dval = 1'b0;
    #1;
    chk("async_rst_tvalid", 64'(o_tvalid), 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    #2;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;

    // A: one continuous row, always ready.
    clear_obs();
    for (int c = 0; c < M; c++) cycle(1'b1, 6'(c % 64), 1'b1);
    repeat (10) cycle(1'b0, 6'd0, 1'b1);
    chk("A_count", 64'(obs_data.size()), 64'd113);
    if (obs_data.size() == 113) begin
      chk("A_w0_data", 64'(obs_data[0]), 64'h03020100);
      chk("A_w0_keep", 64'(obs_keep[0]), 64'hF);
      chk("A_w0_last", 64'(obs_last[0]), 64'd0);
      chk("A_w112_data", 64'(obs_data[112]), 64'h00000100);
      chk("A_w112_keep", 64'(obs_keep[112]), 64'h3);
      chk("A_w112_last", 64'(obs_last[112]), 64'd1);
    end
    chk("A_overflow", 64'(o_overflow), 64'd0);

    // B: same row with i_dval toggling.
    clear_obs();
    for (int c = 0; c < M; c++) begin
      cycle(1'b1, 6'(c % 64), 1'b1);
      cycle(1'b0, 6'd0, 1'b1);
    end
    repeat (10) cycle(1'b0, 6'd0, 1'b1);
    chk("B_count", 64'(obs_data.size()), 64'd113);
    if (obs_data.size() == 113) begin
      chk("B_w0_data", 64'(obs_data[0]), 64'h03020100);
      chk("B_w1_data", 64'(obs_data[1]), 64'h07060504);
      chk("B_w112_data", 64'(obs_data[112]), 64'h00000100);
      chk("B_w112_keep", 64'(obs_keep[112]), 64'h3);
    end

    // C: downstream stalled for a whole row, then drained.
    do_reset();
    clear_obs();
    for (int c = 0; c < M; c++) cycle(1'b1, 6'(c % 64), 1'b0);
    repeat (10) cycle(1'b0, 6'd0, 1'b0);
    chk("C_held_tvalid", 64'(o_tvalid), 64'd1);
    chk("C_held_tdata", 64'(o_tdata), 64'h03020100);
    chk("C_overflow", 64'(o_overflow), 64'd1);
    repeat (30) cycle(1'b0, 6'd0, 1'b1);
    chk("C_drain_count", 64'(obs_data.size()), 64'd16);
    if (obs_data.size() == 16) begin
      chk("C_first", 64'(obs_data[0]), 64'h03020100);
      chk("C_last", 64'(obs_data[15]), 64'h3F3E3D3C);
    end
    chk("C_overflow_sticky", 64'(o_overflow), 64'd1);

    // D: push lands on a full FIFO in the same cycle as a pop.
    do_reset();
    for (int c = 0; c < 64; c++) cycle(1'b1, 6'(c % 64), 1'b0);
    repeat (4) cycle(1'b0, 6'd0, 1'b0);
    chk("D_full_tvalid", 64'(o_tvalid), 64'd1);
    cycle(1'b1, 6'h2A, 1'b0);
    cycle(1'b1, 6'h2B, 1'b0);
    cycle(1'b1, 6'h2C, 1'b0);
    cycle(1'b1, 6'h2D, 1'b0);
    cycle(1'b0, 6'd0, 1'b1);
    repeat (3) cycle(1'b0, 6'd0, 1'b0);
    chk("D_overflow", 64'(o_overflow), 64'd0);
    clear_obs();
    repeat (25) cycle(1'b0, 6'd0, 1'b1);
    chk("D_drain_count", 64'(obs_data.size()), 64'd16);
    if (obs_data.size() == 16) begin
      chk("D_first", 64'(obs_data[0]), 64'h07060504);
      chk("D_last", 64'(obs_data[15]), 64'h2D2C2B2A);
      chk("D_last_keep", 64'(obs_keep[15]), 64'hF);
    end

    // E: reset in the middle of a row.
    do_reset();
    for (int c = 0; c < 6; c++) cycle(1'b1, 6'(c), 1'b0);
    chk("E_pre_tvalid", 64'(o_tvalid), 64'd1);
    do_reset();
    clear_obs();
    for (int c = 0; c < 8; c++) cycle(1'b1, 6'(c + 10), 1'b1);
    repeat (6) cycle(1'b0, 6'd0, 1'b1);
    chk("E_count", 64'(obs_data.size()), 64'd2);
    if (obs_data.size() == 2) begin
      chk("E_w0_data", 64'(obs_data[0]), 64'h0D0C0B0A);
      chk("E_w0_keep", 64'(obs_keep[0]), 64'hF);
      chk("E_w1_data", 64'(obs_data[1]), 64'h11100F0E);
    end

`ifdef DISP_TX_SOF_EN
    // F: three rows with ROWS=2; start of frame on rows 0 and 2 only.
    do_reset();
    clear_obs();
    for (int c = 0; c < 3 * M; c++) cycle(1'b1, 6'(c % 64), 1'b1);
    repeat (10) cycle(1'b0, 6'd0, 1'b1);
    chk("F_count", 64'(obs_data.size()), 64'd339);
    if (obs_user.size() == 339) begin
      int n_user;
      n_user = 0;
      foreach (obs_user[i]) if (obs_user[i]) n_user++;
      chk("F_user_count", 64'(n_user), 64'd2);
      chk("F_user_row0", 64'(obs_user[0]), 64'd1);
      chk("F_user_row1", 64'(obs_user[113]), 64'd0);
      chk("F_user_row2", 64'(obs_user[226]), 64'd1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
